// File: rtl/light_transition_guard_pkg.sv
// -----------------------------------------------------------------------------
// light_transition_guard_pkg
//   Shared definitions for the lamp transition guard:
//     - lane code constants (RED / YELLOW / GREEN / reserved)
//     - lane geometry (4 lanes x 2 bits)
//     - FSM state encoding
//     - lane_map(): extract one lane from a pattern, folding the reserved
//       code onto RED so nothing downstream ever sees it.
// -----------------------------------------------------------------------------
package light_transition_guard_pkg;

  localparam int NUM_LANES = 4;
  localparam int LANE_W    = 2;
  localparam int PAT_W     = NUM_LANES * LANE_W;

  localparam logic [LANE_W-1:0] LANE_RED    = 2'd0;
  localparam logic [LANE_W-1:0] LANE_YELLOW = 2'd1;
  localparam logic [LANE_W-1:0] LANE_GREEN  = 2'd2;
  localparam logic [LANE_W-1:0] LANE_RSVD   = 2'd3;

  typedef enum logic [1:0] {
    ST_HOLD   = 2'd0,
    ST_YELLOW = 2'd1,
    ST_ALLRED = 2'd2
  } state_e;

  // Pull lane 'lane' out of 'pat'; the reserved code reads back as RED.
  function automatic logic [LANE_W-1:0] lane_map(input logic [PAT_W-1:0] pat,
                                                 input int lane);
    logic [LANE_W-1:0] code;
    code = pat[lane*LANE_W +: LANE_W];
    return (code == LANE_RSVD) ? LANE_RED : code;
  endfunction

endpackage

// File: rtl/light_transition_guard_phase_timer.sv
// -----------------------------------------------------------------------------
// phase_timer
//   Loadable down-counter with a zero flag. Counts down by one every clock
//   unless loaded; saturates at zero (never wraps).
// Ports:
//   clk        - clock
//   rst        - asynchronous active-high reset, counter returns to RST_VAL
//   load_i     - load load_val_i this clock (takes priority over counting)
//   load_val_i - value to load
//   zero_o     - counter currently holds zero
// -----------------------------------------------------------------------------
module phase_timer #(
  parameter int            W       = 4,
  parameter logic [W-1:0]  RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         zero_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (load_i) begin
      count_d = load_val_i;
    end else if (count_q != '0) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= RST_VAL;
    end else begin
      count_q <= count_d;
    end
  end

  assign zero_o = (count_q == '0);

endmodule

// File: rtl/light_transition_guard.sv
// -----------------------------------------------------------------------------
// light_transition_guard
//   Registered safety stage in front of the lamp drivers. Forwards the
//   requested 4-lane pattern, but any lane leaving GREEN is walked through a
//   YELLOW phase and an all-RED clearance before the new pattern lands.
//   Accepted patterns are held for a minimum time unless emgOverride is set.
// Parameters:
//   YELLOW_CYCLES   - yellow phase length in clocks (>=1)
//   ALLRED_CYCLES   - all-red clearance length in clocks (>=1)
//   MIN_HOLD_CYCLES - minimum clocks between accepted patterns (>=1)
// Ports:
//   clk         - clock
//   rst         - asynchronous active-high reset (forces all-red, restarts
//                 clearance)
//   reqLights   - requested pattern, lane i at [2i+1:2i]
//   emgOverride - skip whatever remains of the minimum hold time
//   lampOut     - registered lamp pattern (reserved code never driven)
//   busy        - registered, high whenever not in HOLD
// -----------------------------------------------------------------------------
module light_transition_guard
  import light_transition_guard_pkg::*;
#(
  parameter int YELLOW_CYCLES   = 4,
  parameter int ALLRED_CYCLES   = 2,
  parameter int MIN_HOLD_CYCLES = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [PAT_W-1:0] reqLights,
  input  logic             emgOverride,
  output logic [PAT_W-1:0] lampOut,
  output logic             busy
);

  localparam int MAX_YA = (YELLOW_CYCLES > ALLRED_CYCLES) ? YELLOW_CYCLES : ALLRED_CYCLES;
  localparam int MAX_P  = (MAX_YA > MIN_HOLD_CYCLES) ? MAX_YA : MIN_HOLD_CYCLES;
  localparam int CNT_W  = (MAX_P < 1) ? 1 : $clog2(MAX_P + 1);

  localparam logic [CNT_W-1:0] YELLOW_LOAD = CNT_W'(YELLOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] ALLRED_LOAD = CNT_W'(ALLRED_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(MIN_HOLD_CYCLES - 1);

  state_e           state_q, state_d;
  logic [PAT_W-1:0] lamp_q, lamp_d;
  logic             busy_q, busy_d;

  logic             phase_load, phase_zero;
  logic [CNT_W-1:0] phase_val;
  logic             hold_load, hold_zero;

  // Request with reserved codes folded to RED, plus the yellow pattern that
  // would result if a change were accepted now.
  logic [PAT_W-1:0]     req_mapped;
  logic [PAT_W-1:0]     yellow_pat;
  logic [NUM_LANES-1:0] drop_lane;

  generate
    for (genvar gi = 0; gi < NUM_LANES; gi++) begin : g_lane
      logic [LANE_W-1:0] cur_code;
      logic [LANE_W-1:0] req_code;

      assign cur_code = lamp_q[gi*LANE_W +: LANE_W];
      assign req_code = lane_map(reqLights, gi);

      assign req_mapped[gi*LANE_W +: LANE_W] = req_code;
      // A lane "drops" only when it is leaving GREEN; other transitions are safe.
      assign drop_lane[gi] = (cur_code == LANE_GREEN) && (req_code != LANE_GREEN);
      assign yellow_pat[gi*LANE_W +: LANE_W] = drop_lane[gi] ? LANE_YELLOW : cur_code;
    end
  endgenerate

  always_comb begin
    state_d    = state_q;
    lamp_d     = lamp_q;
    phase_load = 1'b0;
    phase_val  = YELLOW_LOAD;
    hold_load  = 1'b0;

    case (state_q)
      ST_HOLD: begin
        if ((hold_zero || emgOverride) && (req_mapped != lamp_q)) begin
          if (|drop_lane) begin
            lamp_d     = yellow_pat;
            phase_load = 1'b1;
            phase_val  = YELLOW_LOAD;
            state_d    = ST_YELLOW;
          end else begin
            lamp_d    = req_mapped;
            hold_load = 1'b1;
            state_d   = ST_HOLD;
          end
        end
      end

      ST_YELLOW: begin
        // emgOverride deliberately has no effect here.
        if (phase_zero) begin
          lamp_d     = '0;
          phase_load = 1'b1;
          phase_val  = ALLRED_LOAD;
          state_d    = ST_ALLRED;
        end
      end

      ST_ALLRED: begin
        lamp_d = '0;
        // Whatever is requested on the final clearance edge wins; earlier
        // request changes were never looked at.
        if (phase_zero) begin
          lamp_d    = req_mapped;
          hold_load = 1'b1;
          state_d   = ST_HOLD;
        end
      end

      default: begin
        lamp_d     = '0;
        phase_load = 1'b1;
        phase_val  = ALLRED_LOAD;
        state_d    = ST_ALLRED;
      end
    endcase

    busy_d = (state_d != ST_HOLD);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_ALLRED;
      lamp_q  <= '0;
      busy_q  <= 1'b1;
    end else begin
      state_q <= state_d;
      lamp_q  <= lamp_d;
      busy_q  <= busy_d;
    end
  end

  // Yellow / all-red duration. Reset value starts the power-up clearance.
  phase_timer #(
    .W       (CNT_W),
    .RST_VAL (ALLRED_LOAD)
  ) u_phase_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (phase_load),
    .load_val_i (phase_val),
    .zero_o     (phase_zero)
  );

  // Minimum hold between accepted patterns; reset to zero so the first
  // post-clearance request is not delayed further.
  phase_timer #(
    .W       (CNT_W),
    .RST_VAL ('0)
  ) u_hold_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (hold_load),
    .load_val_i (HOLD_LOAD),
    .zero_o     (hold_zero)
  );

  assign lampOut = lamp_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_light_transition_guard.sv
// -----------------------------------------------------------------------------
// tb_light_transition_guard
//   Directed bench for light_transition_guard with default parameters
//   (YELLOW=4, ALLRED=2, MIN_HOLD=8). Inputs change and outputs are sampled
//   on the falling edge; each sample reflects the preceding rising edge.
// -----------------------------------------------------------------------------
module tb_light_transition_guard;

  logic       clk;
  logic       rst;
  logic [7:0] reqLights;
  logic       emgOverride;
  logic [7:0] lampOut;
  logic       busy;

  int checks;
  int errors;

  light_transition_guard #(
    .YELLOW_CYCLES   (4),
    .ALLRED_CYCLES   (2),
    .MIN_HOLD_CYCLES (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .reqLights   (reqLights),
    .emgOverride (emgOverride),
    .lampOut     (lampOut),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance past one rising edge; return on the following falling edge.
  task automatic step();
    @(negedge clk);
  endtask

  // Wait (bounded) until the given pattern is applied and the guard is idle.
  task automatic wait_apply(input logic [7:0] exp, input int budget, input string name);
    int n;
    n = 0;
    while (!(lampOut === exp && busy === 1'b0) && n < budget) begin
      step();
      n++;
    end
    checks++;
    if (!(lampOut === exp && busy === 1'b0)) begin
      errors++;
      $display("FAIL %s: lampOut=%h busy=%b, required %h busy=0 within %0d cycles",
               name, lampOut, busy, exp, budget);
    end else begin
      $display("apply %s: lampOut=%h after %0d cycles", name, lampOut, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    reqLights = 8'h0A;
    emgOverride = 1'b0;
    step();
    checks++;
    if (lampOut !== 8'h00 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: lampOut=%h busy=%b, required 00 busy=1", lampOut, busy);
    end else $display("reset_state: lampOut=%h busy=%b", lampOut, busy);
    rst = 1'b0;
    step();
    checks++;
    if (lampOut !== 8'h00 || busy !== 1'b1) begin
      errors++;
      $display("FAIL reset_clear: lampOut=%h busy=%b, required 00 busy=1", lampOut, busy);
    end else $display("reset_clear: lampOut=%h busy=%b", lampOut, busy);
    step();
    checks++;
    if (lampOut !== 8'h0A || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_first_apply: lampOut=%h busy=%b, required 0a busy=0", lampOut, busy);
    end else $display("reset_first_apply: lampOut=%h busy=%b", lampOut, busy);
  endtask

  // From 0A (just applied) request A0: 7 held edges, then 4x05, 2x00, A0.
  task automatic test_drop();
    logic [7:0] exp_l [14];
    logic       exp_b [14];
    int         busy_cnt;
    for (int i = 0; i < 14; i++) begin
      exp_l[i] = (i < 7) ? 8'h0A : (i < 11) ? 8'h05 : (i < 13) ? 8'h00 : 8'hA0;
      exp_b[i] = (i >= 7 && i < 13);
    end
    busy_cnt = 0;
    reqLights = 8'hA0;
    for (int i = 0; i < 14; i++) begin
      step();
      if (busy === 1'b1) busy_cnt++;
      checks++;
      if (lampOut !== exp_l[i] || busy !== exp_b[i]) begin
        errors++;
        $display("FAIL drop_seq[%0d]: lampOut=%h busy=%b, required %h busy=%b",
                 i, lampOut, busy, exp_l[i], exp_b[i]);
      end else $display("drop_seq[%0d]: lampOut=%h busy=%b", i, lampOut, busy);
    end
    checks++;
    if (busy_cnt != 6) begin
      errors++;
      $display("FAIL drop_busy_len: busy cycles=%0d, required 6", busy_cnt);
    end else $display("drop_busy_len: %0d", busy_cnt);
  endtask

  // Reach 00, then 00 -> 22 must be a one-edge direct change with busy low.
  task automatic test_direct();
    reqLights = 8'h00;
    wait_apply(8'h00, 40, "to_00");
    reqLights = 8'h22;
    for (int i = 0; i < 8; i++) begin
      step();
      checks++;
      if (lampOut !== ((i < 7) ? 8'h00 : 8'h22) || busy !== 1'b0) begin
        errors++;
        $display("FAIL direct[%0d]: lampOut=%h busy=%b, required %h busy=0",
                 i, lampOut, busy, (i < 7) ? 8'h00 : 8'h22);
      end else $display("direct[%0d]: lampOut=%h busy=%b", i, lampOut, busy);
    end
  endtask

  // Request 3 cycles after apply: held off; then the same with emgOverride.
  task automatic test_hold_off();
    reqLights = 8'h0A;
    wait_apply(8'h0A, 40, "to_0a");
    repeat (3) step();
    reqLights = 8'hA0;
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (lampOut !== ((i < 4) ? 8'h0A : 8'h05) || busy !== (i == 4)) begin
        errors++;
        $display("FAIL hold_off[%0d]: lampOut=%h busy=%b, required %h busy=%b",
                 i, lampOut, busy, (i < 4) ? 8'h0A : 8'h05, (i == 4));
      end else $display("hold_off[%0d]: lampOut=%h busy=%b", i, lampOut, busy);
    end
    wait_apply(8'hA0, 20, "to_a0");
    repeat (3) step();
    reqLights = 8'h0A;
    emgOverride = 1'b1;
    // Override skips the hold but must not shorten yellow.
    for (int i = 0; i < 5; i++) begin
      step();
      checks++;
      if (lampOut !== ((i < 4) ? 8'h50 : 8'h00) || busy !== 1'b1) begin
        errors++;
        $display("FAIL emg[%0d]: lampOut=%h busy=%b, required %h busy=1",
                 i, lampOut, busy, (i < 4) ? 8'h50 : 8'h00);
      end else $display("emg[%0d]: lampOut=%h busy=%b", i, lampOut, busy);
    end
    emgOverride = 1'b0;
    wait_apply(8'h0A, 20, "emg_apply");
  endtask

  // Revert request during yellow: sequence still completes, then 0A.
  task automatic test_revert();
    int n;
    reqLights = 8'hA0;
    n = 0;
    while (lampOut !== 8'h05 && n < 20) begin
      step();
      n++;
    end
    checks++;
    if (lampOut !== 8'h05) begin
      errors++;
      $display("FAIL revert_yellow_start: lampOut=%h, required 05", lampOut);
    end else $display("revert_yellow_start: after %0d cycles", n);
    reqLights = 8'h0A;
    for (int i = 0; i < 6; i++) begin
      step();
      checks++;
      if (lampOut !== ((i < 3) ? 8'h05 : (i < 5) ? 8'h00 : 8'h0A) || busy !== (i < 5)) begin
        errors++;
        $display("FAIL revert[%0d]: lampOut=%h busy=%b, required %h busy=%b", i, lampOut, busy,
                 (i < 3) ? 8'h05 : (i < 5) ? 8'h00 : 8'h0A, (i < 5));
      end else $display("revert[%0d]: lampOut=%h busy=%b", i, lampOut, busy);
    end
  endtask

  // Reserved codes map to RED and are never driven.
  task automatic test_reserved();
    int  rsvd_cnt;
    bit  seen_busy;
    rsvd_cnt = 0;
    seen_busy = 0;
    reqLights = 8'hFF;
    for (int n = 0; n < 40; n++) begin
      step();
      for (int i = 0; i < 4; i++) if (lampOut[2*i +: 2] === 2'b11) rsvd_cnt++;
      if (busy === 1'b1) seen_busy = 1;
      if (seen_busy && busy === 1'b0) break;
    end
    checks++;
    if (lampOut !== 8'h00 || !seen_busy || busy !== 1'b0) begin
      errors++;
      $display("FAIL rsvd_apply: lampOut=%h busy=%b seen_busy=%0d, required 00 busy=0 seen_busy=1",
               lampOut, busy, seen_busy);
    end else $display("rsvd_apply: lampOut=%h", lampOut);
    repeat (10) begin
      step();
      for (int i = 0; i < 4; i++) if (lampOut[2*i +: 2] === 2'b11) rsvd_cnt++;
    end
    checks++;
    if (lampOut !== 8'h00 || busy !== 1'b0) begin
      errors++;
      $display("FAIL rsvd_steady: lampOut=%h busy=%b, required 00 busy=0", lampOut, busy);
    end else $display("rsvd_steady: lampOut=%h busy=%b", lampOut, busy);
    checks++;
    if (rsvd_cnt != 0) begin
      errors++;
      $display("FAIL rsvd_code: reserved lanes seen=%0d, required 0", rsvd_cnt);
    end else $display("rsvd_code: reserved lanes=%0d", rsvd_cnt);
  endtask

  // Reset asserted mid-yellow forces all-red at once and restarts clearance.
  task automatic test_rst_mid();
    reqLights = 8'h0A;
    emgOverride = 1'b1;
    step();
    checks++;
    if (lampOut !== 8'h0A || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_setup: lampOut=%h busy=%b, required 0a busy=0", lampOut, busy);
    end else $display("rst_mid_setup: lampOut=%h busy=%b", lampOut, busy);
    reqLights = 8'hA0;
    step();
    checks++;
    if (lampOut !== 8'h05 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_yellow: lampOut=%h busy=%b, required 05 busy=1", lampOut, busy);
    end else $display("rst_mid_yellow: lampOut=%h busy=%b", lampOut, busy);
    step();
    #2 rst = 1'b1;
    #1;
    checks++;
    if (lampOut !== 8'h00 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_async: lampOut=%h busy=%b, required 00 busy=1", lampOut, busy);
    end else $display("rst_mid_async: lampOut=%h busy=%b", lampOut, busy);
    emgOverride = 1'b0;
    reqLights = 8'h0A;
    @(negedge clk);
    rst = 1'b0;
    step();
    checks++;
    if (lampOut !== 8'h00 || busy !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_clear: lampOut=%h busy=%b, required 00 busy=1", lampOut, busy);
    end else $display("rst_mid_clear: lampOut=%h busy=%b", lampOut, busy);
    step();
    checks++;
    if (lampOut !== 8'h0A || busy !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_apply: lampOut=%h busy=%b, required 0a busy=0", lampOut, busy);
    end else $display("rst_mid_apply: lampOut=%h busy=%b", lampOut, busy);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst = 1'b1;
    reqLights = 8'h00;
    emgOverride = 1'b0;
    test_reset();
    test_drop();
    test_direct();
    test_hold_off();
    test_revert();
    test_reserved();
    test_rst_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/light_transition_guard.md
# light_transition_guard

Registered safety stage between the light-output mux and the lamp drivers. It accepts the 8-bit lane-light pattern selected by the mode logic and forwards it to the lamps. Any change that takes a lane out of green is forced through a yellow phase and an all-red clearance phase. A minimum hold time applies between accepted patterns.

## Interface
Parameters:
- `YELLOW_CYCLES`, default 4: length of the yellow phase in clocks; must be ≥1.
- `ALLRED_CYCLES`, default 2: length of the all-red clearance in clocks; must be ≥1.
- `MIN_HOLD_CYCLES`, default 8: minimum clocks a newly applied pattern stays before the next change is accepted; must be ≥1.

Ports:
- `clk`, in, 1: single clock; all state changes on the rising edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `reqLights`, in, 8: requested pattern; 4 lanes × 2-bit code, lane i at bits [2i+1:2i].
- `emgOverride`, in, 1: when high, the remaining `MIN_HOLD` time is skipped.
- `lampOut`, out, 8: registered lamp pattern, same encoding as `reqLights`.
- `busy`, out, 1: registered; high in every state except `HOLD`.

## Operation
- Lane codes:
  - 0 = RED, 1 = YELLOW, 2 = GREEN.
  - 3 = reserved. On input it is treated as RED (mapped to 0 before any comparison). It is never driven on `lampOut`.
- States: `HOLD`, `YELLOW`, `ALLRED`.
- `HOLD`:
  - Holds `lampOut`. The hold counter counts down to 0.
  - A change is considered only when the hold counter is 0, or when `emgOverride` is high.
  - A dropping lane is one whose current code is GREEN and whose requested code is not GREEN.
  - A change with no dropping lane loads the mapped request into `lampOut` directly, reloads the hold counter to `MIN_HOLD_CYCLES-1`, and stays in `HOLD`.
  - A change with at least one dropping lane sets the dropping lanes to YELLOW and leaves the other lanes unchanged. The phase timer loads `YELLOW_CYCLES-1` and the state goes to `YELLOW`.
  - If the request equals the current pattern, nothing changes.
- `YELLOW`: hold `lampOut`. When the timer reaches 0, set `lampOut` to 8'h00, load the timer with `ALLRED_CYCLES-1`, and go to `ALLRED`.
- `ALLRED`:
  - Hold all lanes RED. When the timer reaches 0, apply the mapped `reqLights` sampled on that edge.
  - On that edge, reload the hold counter to `MIN_HOLD_CYCLES-1` and go to `HOLD`.
- Request changes during `YELLOW` and `ALLRED` are ignored. Only the value present on the final `ALLRED` edge is applied.
- The sequence always runs to completion: green→yellow→green is never produced, even if the request reverts mid-sequence.
- `emgOverride` never shortens `YELLOW` or `ALLRED`.
- Reset:
  - `lampOut` = 8'h00 and `busy` = 1.
  - State = `ALLRED`, timer = `ALLRED_CYCLES-1`, hold counter = 0.
  - The first pattern is therefore applied only after the full clearance.

## Timing
- Direct change (no dropping lane), request sampled at edge k: `lampOut` shows the new value after edge k. Latency is 1 edge and `busy` stays low.
- Change with a dropping lane, sampled at edge k:
  - Yellow is visible from edge k.
  - All-red is visible from edge k+`YELLOW_CYCLES`.
  - The new pattern is visible from edge k+`YELLOW_CYCLES`+`ALLRED_CYCLES`.
  - `busy` is high from edge k until the apply edge, then low.
- After any apply edge a, the next change is accepted no earlier than edge a+`MIN_HOLD_CYCLES`, unless `emgOverride` is high.
- Reset released before edge r: the first apply occurs at edge r+`ALLRED_CYCLES`-1.
- Asserting `rst` mid-sequence forces all-red immediately (asynchronously) and restarts the clearance.
- Counter widths are $clog2 of (the maximum parameter value + 1). Counters saturate at 0 and never wrap.

## Structure
- A shared package holds:
  - lane code constants (RED, YELLOW, GREEN, RSVD);
  - the lane count (4) and lane width (2);
  - the state enum;
  - a lane-extract/reserved-mapping function.
- One sub-module, `phase_timer`: a loadable down-counter with a zero flag. It is instantiated twice, once as the phase timer and once as the hold counter.

## Test plan
- Reset then `reqLights`=8'h0A:
  - 8'h00 is held for `ALLRED_CYCLES`-1 edges after release;
  - then 8'h0A is applied and `busy` falls.
- From 8'h0A, request 8'hA0 after the hold expires:
  - 8'h05 for 4 cycles, then 8'h00 for 2 cycles, then 8'hA0;
  - `busy` is high for exactly 6 cycles.
- From 8'h00, request 8'h22 after the hold expires: 8'h22 appears after one edge and `busy` never rises.
- Change 8'h0A→8'hA0 requested 3 cycles after an apply: it is held off until the hold reaches 0. The same request with `emgOverride`=1 starts yellow on the next edge.
- During `YELLOW`, switch `reqLights` back to 8'h0A: the yellow and all-red phases still complete, then 8'h0A is applied. Request 8'hFF: `lampOut` is 8'h00 and code 3 never appears.
- Assert `rst` mid-`YELLOW`: `lampOut` is 8'h00 immediately, and after release the sequence restarts as in the reset scenario.
